// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase controller.
// Optional NIGHT_FLASH_EN adds the FLASH phase encoding.
package traffic_pkg;
  localparam int TMR_W = 6;

  localparam logic [1:0] LED_RED    = 2'b00;
  localparam logic [1:0] LED_GREEN  = 2'b01;
  localparam logic [1:0] LED_YELLOW = 2'b10;
  localparam logic [1:0] LED_OFF    = 2'b11;

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR_A = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR_B = 3'd5
`ifdef NIGHT_FLASH_EN
    , FLASH = 3'd6
`endif
  } phase_e;

  // {ns, ew} lamp pair for the normal phases; anything else is all-red
  function automatic logic [3:0] lamp_map(phase_e s);
    case (s)
      NS_G:    return {LED_GREEN, LED_RED};
      NS_Y:    return {LED_YELLOW, LED_RED};
      EW_G:    return {LED_RED, LED_GREEN};
      EW_Y:    return {LED_RED, LED_YELLOW};
      default: return {LED_RED, LED_RED};
    endcase
  endfunction
endpackage

// File: rtl/intersection_phase_ctrl_if.sv
// Control/status bundle between the intersection controller and its environment.
// night_mode exists only when NIGHT_FLASH_EN is defined.
interface intersection_phase_ctrl_if;
  import traffic_pkg::*;
  logic             tick;
  logic             ped_req;
`ifdef NIGHT_FLASH_EN
  logic             night_mode;
`endif
  logic [1:0]       led_ns;
  logic [1:0]       led_ew;
  logic [TMR_W-1:0] timer_value;
  logic             ped_ack;

  modport master (
`ifdef NIGHT_FLASH_EN
    output night_mode,
`endif
    output tick, ped_req,
    input  led_ns, led_ew, timer_value, ped_ack
  );

  modport slave (
`ifdef NIGHT_FLASH_EN
    input  night_mode,
`endif
    input  tick, ped_req,
    output led_ns, led_ew, timer_value, ped_ack
  );
endinterface

// File: rtl/intersection_phase_ctrl_timer.sv
// Phase down-counter: load wins, otherwise decrement on tick until zero.
// expire flags the tick that arrives while the count is already zero.
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [TMR_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             tick,
  output logic [TMR_W-1:0] count,
  output logic             expire
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count <= RST_VAL;
    else if (load)               count <= load_val;
    else if (tick && count != 0) count <= count - TMR_W'(1);
  end

  assign expire = tick & (count == '0);
endmodule

// File: rtl/intersection_phase_ctrl.sv
// Two-road intersection sequencer with pedestrian green truncation.
// Define NIGHT_FLASH_EN to add night_mode and the flashing-yellow FLASH phase.
module intersection_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int G_NS    = 15,
  parameter int G_EW    = 12,
  parameter int Y_TIME  = 3,
  parameter int RED_CLR = 2,
  parameter int MIN_G   = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  intersection_phase_ctrl_if.slave   bus
);
  localparam logic [TMR_W-1:0] GNS_LD = TMR_W'(G_NS - 1);
  localparam logic [TMR_W-1:0] GEW_LD = TMR_W'(G_EW - 1);
  localparam logic [TMR_W-1:0] Y_LD   = TMR_W'(Y_TIME - 1);
  localparam logic [TMR_W-1:0] RED_LD = TMR_W'(RED_CLR - 1);
  localparam logic [TMR_W-1:0] MIN_LD = TMR_W'(MIN_G - 1);

  phase_e           state, state_nx;
  logic             load, expire, ped_pend, ar_entry;
  logic [TMR_W-1:0] load_val, count;
  logic [3:0]       lamp_nx;

  phase_timer #(.RST_VAL(RED_LD)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .tick(bus.tick), .count(count), .expire(expire)
  );

  assign bus.timer_value = count;
  assign ar_entry = (state_nx != state) && (state_nx == AR_A || state_nx == AR_B);

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_val = '0;
    case (state)
      NS_G: if (expire) begin
              state_nx = NS_Y; load = 1'b1; load_val = Y_LD;
            end else if (ped_pend && count > MIN_LD) begin
              load = 1'b1; load_val = MIN_LD;
            end
      NS_Y: if (expire) begin state_nx = AR_A; load = 1'b1; load_val = RED_LD; end
      AR_A: if (expire) begin
`ifdef NIGHT_FLASH_EN
              if (bus.night_mode) state_nx = FLASH; else
`endif
              begin state_nx = EW_G; load = 1'b1; load_val = GEW_LD; end
            end
      EW_G: if (expire) begin
              state_nx = EW_Y; load = 1'b1; load_val = Y_LD;
            end else if (ped_pend && count > MIN_LD) begin
              load = 1'b1; load_val = MIN_LD;
            end
      EW_Y: if (expire) begin state_nx = AR_B; load = 1'b1; load_val = RED_LD; end
      AR_B: if (expire) begin
`ifdef NIGHT_FLASH_EN
              if (bus.night_mode) state_nx = FLASH; else
`endif
              begin state_nx = NS_G; load = 1'b1; load_val = GNS_LD; end
            end
`ifdef NIGHT_FLASH_EN
      // counter is already zero on entry and a tick at zero never decrements
      FLASH: if (!bus.night_mode) begin state_nx = AR_B; load = 1'b1; load_val = RED_LD; end
`endif
      default: begin state_nx = AR_B; load = 1'b1; load_val = RED_LD; end
    endcase
  end

  always_comb begin
    lamp_nx = lamp_map(state_nx);
`ifdef NIGHT_FLASH_EN
    if (state_nx == FLASH) begin
      if (state != FLASH)  lamp_nx = {LED_YELLOW, LED_YELLOW};
      else if (bus.tick)   lamp_nx = {bus.led_ns ^ 2'b01, bus.led_ew ^ 2'b01};
      else                 lamp_nx = {bus.led_ns, bus.led_ew};
    end
`endif
  end

  // a request landing in the serving cycle stays pending for the next green
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= AR_B;
      ped_pend    <= 1'b0;
      bus.ped_ack <= 1'b0;
      bus.led_ns  <= LED_RED;
      bus.led_ew  <= LED_RED;
    end else begin
      state       <= state_nx;
      ped_pend    <= bus.ped_req | (ped_pend & ~ar_entry);
      bus.ped_ack <= ar_entry & ped_pend;
      bus.led_ns  <= lamp_nx[3:2];
      bus.led_ew  <= lamp_nx[1:0];
    end
  end
endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// Directed bench for intersection_phase_ctrl: a phase-sequence vector table plus
// hand-written ped, reset and (with NIGHT_FLASH_EN) night-flash sequences.
module tb_intersection_phase_ctrl;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  intersection_phase_ctrl_if ifc();
  intersection_phase_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic       tick;
    logic       ped;
    logic [1:0] ns;
    logic [1:0] ew;
    logic [5:0] tv;
    logic       ack;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_st(input string nm, input logic [1:0] ns, input logic [1:0] ew,
                        input logic [5:0] tv);
    chk({nm, ".ns"}, 32'(ifc.led_ns), 32'(ns));
    chk({nm, ".ew"}, 32'(ifc.led_ew), 32'(ew));
    chk({nm, ".tv"}, 32'(ifc.timer_value), 32'(tv));
  endtask

  task automatic chk_ack(input string nm, input logic ack);
    chk({nm, ".ack"}, 32'(ifc.ped_ack), 32'(ack));
  endtask

  task automatic cyc(input logic tk, input logic pr);
    ifc.tick = tk;
    ifc.ped_req = pr;
    @(posedge clk);
    #1;
    ifc.tick = 1'b0;
    ifc.ped_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.tick = 1'b0;
    ifc.ped_req = 1'b0;
`ifdef NIGHT_FLASH_EN
    ifc.night_mode = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // tick every cycle until the given display appears, bounded
  task automatic run_to(input string nm, input logic [1:0] ns, input logic [1:0] ew,
                        input logic [5:0] tv);
    int k = 0;
    while (!(ifc.led_ns == ns && ifc.led_ew == ew && ifc.timer_value == tv) && k < 200) begin
      cyc(1'b1, 1'b0);
      k++;
    end
    chk({nm, ".reach"}, 32'(k < 200), 32'(1));
  endtask

  task automatic add_phase(input logic [1:0] ns, input logic [1:0] ew, input int dur);
    for (int k = dur - 1; k >= 0; k--) tbl.push_back('{1'b1, 1'b0, ns, ew, 6'(k), 1'b0});
  endtask

  initial begin
    int green, hold_err;
    logic [5:0] prev;

    // expected display after reset and after each ticking cycle
    add_phase(LED_RED, LED_RED, 2);
    add_phase(LED_GREEN, LED_RED, 15);
    add_phase(LED_YELLOW, LED_RED, 3);
    add_phase(LED_RED, LED_RED, 2);
    add_phase(LED_RED, LED_GREEN, 12);
    add_phase(LED_RED, LED_YELLOW, 3);
    add_phase(LED_RED, LED_RED, 2);
    tbl.push_back('{1'b1, 1'b0, LED_GREEN, LED_RED, 6'd14, 1'b0});

    // 1: full cycle, tick every clk
    do_reset();
    #1;
    chk_st("t1.rst", tbl[0].ns, tbl[0].ew, tbl[0].tv);
    chk_ack("t1.rst", tbl[0].ack);
    for (int i = 1; i < tbl.size(); i++) begin
      cyc(tbl[i].tick, tbl[i].ped);
      chk_st($sformatf("t1.v%0d", i), tbl[i].ns, tbl[i].ew, tbl[i].tv);
      chk_ack($sformatf("t1.v%0d", i), tbl[i].ack);
    end

    // 2: tick every 4th clk
    do_reset();
    green = 0;
    hold_err = 0;
    prev = ifc.timer_value;
    for (int c = 0; c < 100; c++) begin
      cyc(c % 4 == 0, 1'b0);
      if (ifc.led_ns == LED_GREEN) begin
        green++;
        if (c % 4 != 0 && ifc.timer_value != prev) hold_err++;
      end
      prev = ifc.timer_value;
    end
    chk("t2.green_clks", 32'(green), 32'd60);
    chk("t2.hold_err", 32'(hold_err), 32'd0);
    chk_st("t2.end", LED_RED, LED_GREEN, 6'd8);

    // 3: request early in NS_G truncates to MIN_G
    do_reset();
    run_to("t3", LED_GREEN, LED_RED, 6'd12);
    cyc(1'b0, 1'b1);
    chk_st("t3.latch", LED_GREEN, LED_RED, 6'd12);
    cyc(1'b0, 1'b0);
    chk_st("t3.trunc", LED_GREEN, LED_RED, 6'd4);
    repeat (4) cyc(1'b1, 1'b0);
    chk_st("t3.min_end", LED_GREEN, LED_RED, 6'd0);
    cyc(1'b1, 1'b0);
    chk_st("t3.ns_y", LED_YELLOW, LED_RED, 6'd2);
    chk_ack("t3.ns_y", 1'b0);
    repeat (3) cyc(1'b1, 1'b0);
    chk_st("t3.ar_a", LED_RED, LED_RED, 6'd1);
    chk_ack("t3.ar_a", 1'b1);
    cyc(1'b1, 1'b0);
    chk_ack("t3.ack_end", 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk_st("t3.ew_full", LED_RED, LED_GREEN, 6'd10);

    // 4: late request is not truncated; request in all-red acts on next green
    do_reset();
    run_to("t4", LED_GREEN, LED_RED, 6'd3);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk_st("t4.no_trunc", LED_GREEN, LED_RED, 6'd3);
    repeat (4) cyc(1'b1, 1'b0);
    chk_st("t4.ns_y", LED_YELLOW, LED_RED, 6'd2);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk_st("t4.ar_a", LED_RED, LED_RED, 6'd1);
    chk_ack("t4.ar_a", 1'b1);
    cyc(1'b1, 1'b1);
    chk_ack("t4.ar_a_req", 1'b0);
    cyc(1'b1, 1'b0);
    chk_st("t4.ew_entry", LED_RED, LED_GREEN, 6'd11);
    cyc(1'b1, 1'b0);
    chk_st("t4.ew_trunc", LED_RED, LED_GREEN, 6'd4);
    cyc(1'b1, 1'b0);
    chk_st("t4.ew_dec", LED_RED, LED_GREEN, 6'd3);

    // 5: request coincident with AR_B entry stays pending
    do_reset();
    run_to("t5", LED_RED, LED_YELLOW, 6'd2);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk_st("t5.ar_b", LED_RED, LED_RED, 6'd1);
    chk_ack("t5.ar_b", 1'b1);
    cyc(1'b1, 1'b0);
    chk_ack("t5.ack_end", 1'b0);
    cyc(1'b1, 1'b0);
    chk_st("t5.ns_entry", LED_GREEN, LED_RED, 6'd14);
    cyc(1'b1, 1'b0);
    chk_st("t5.ns_trunc", LED_GREEN, LED_RED, 6'd4);

    // 6: asynchronous reset mid-EW_Y
    do_reset();
    run_to("t6", LED_RED, LED_YELLOW, 6'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_st("t6.async", LED_RED, LED_RED, 6'd1);
    chk_ack("t6.async", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);
    chk_st("t6.hold", LED_RED, LED_RED, 6'd1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk_st("t6.first_green", LED_GREEN, LED_RED, 6'd14);

`ifdef NIGHT_FLASH_EN
    // 7: night flash from all-red and back
    do_reset();
    ifc.night_mode = 1'b1;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk_st("t7.flash0", LED_YELLOW, LED_YELLOW, 6'd0);
    cyc(1'b1, 1'b0);
    chk_st("t7.flash1", LED_OFF, LED_OFF, 6'd0);
    cyc(1'b0, 1'b0);
    chk_st("t7.hold", LED_OFF, LED_OFF, 6'd0);
    cyc(1'b1, 1'b0);
    chk_st("t7.flash2", LED_YELLOW, LED_YELLOW, 6'd0);
    ifc.night_mode = 1'b0;
    cyc(1'b0, 1'b0);
    chk_st("t7.exit", LED_RED, LED_RED, 6'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
